counter_gen2: RTL and testbench

//   Parametrised next-generation mode counter: up by 1, down by 1, down by STEP, or parallel load.

---
 rtl/counter_gen2.sv | 110 +++++++++++
 tb/tb_counter_gen2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_gen2.sv
// Mode counter slice (+1, -1, -STEP, load) with cascade carry and a saturating wrap-event counter.
// Define COUNTER_GEN2_SAT_EN to clamp at the bounds instead of wrapping.
module counter_gen2 #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3,
    parameter int WCW   = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             CIN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD,
    output logic             COUT,
    output logic [WCW-1:0]   WRAP_CNT
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);

    if ((STEP < 1) || (STEP > (2**WIDTH) - 1)) begin : g_step_check
        $error("counter_gen2: STEP=%0d outside legal range 1..%0d", STEP, (2**WIDTH) - 1);
    end

    logic [WIDTH-1:0] q_reg, q_next;
    logic             rco_reg, rco_next;
    logic             load_reg, load_next;
    logic [WCW-1:0]   wrap_reg, wrap_next;
    logic             adv;
    logic             term;
    logic [WIDTH:0]   step_diff;

    assign adv = ENABLE & CIN;

    // Extra top bit of the difference is the borrow, i.e. Q < STEP.
    assign step_diff = {1'b0, q_reg} - STEP_EXT;

    always_comb begin
        term   = 1'b0;
        q_next = q_reg;
        case (MODO)
            2'b00: begin
                term = (q_reg == MAX_VAL);
`ifdef COUNTER_GEN2_SAT_EN
                q_next = term ? MAX_VAL : q_reg + 1'b1;
`else
                q_next = q_reg + 1'b1;
`endif
            end
            2'b01: begin
                term = (q_reg == '0);
`ifdef COUNTER_GEN2_SAT_EN
                q_next = term ? '0 : q_reg - 1'b1;
`else
                q_next = q_reg - 1'b1;
`endif
            end
            2'b10: begin
                term = step_diff[WIDTH];
`ifdef COUNTER_GEN2_SAT_EN
                q_next = term ? '0 : step_diff[WIDTH-1:0];
`else
                q_next = step_diff[WIDTH-1:0];
`endif
            end
            default: begin
                term   = 1'b0;
                q_next = D;
            end
        endcase
    end

    always_comb begin
        rco_next  = adv & term;
        load_next = adv & (MODO == 2'b11);
        wrap_next = wrap_reg;
        if (load_next) begin
            wrap_next = '0;
        end else if (rco_next && (wrap_reg != {WCW{1'b1}})) begin
            wrap_next = wrap_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            q_reg    <= '0;
            rco_reg  <= 1'b0;
            load_reg <= 1'b0;
            wrap_reg <= '0;
        end else begin
            if (adv) begin
                q_reg <= q_next;
            end
            rco_reg  <= rco_next;
            load_reg <= load_next;
            wrap_reg <= wrap_next;
        end
    end

    assign Q        = q_reg;
    assign RCO      = rco_reg;
    assign LOAD     = load_reg;
    assign WRAP_CNT = wrap_reg;
    // Lookahead carry stays combinational so chained slices advance in the same edge.
    assign COUT     = adv & term;

endmodule

// File: tb/tb_counter_gen2.sv
// Self-checking bench for counter_gen2 (WIDTH=4, STEP=3, WCW=8): directed scenarios,
// a two-slice cascade and randomized runs against an integer-arithmetic reference model.
module tb_counter_gen2;

`ifdef COUNTER_GEN2_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, cin;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco, load, cout;
    logic [7:0] wrap_cnt;

    // cascade pair
    logic       c_reset, c_en;
    logic [1:0] c_modo;
    logic [3:0] lo_d, hi_d, lo_q, hi_q;
    logic       lo_rco, hi_rco, lo_load, hi_load, lo_cout, hi_cout, hi_cin;
    logic [7:0] lo_wrap, hi_wrap;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_q, m_wrap;
    bit m_rco, m_load;

    always #5 clk = ~clk;

    counter_gen2 #(.WIDTH(4), .STEP(3), .WCW(8)) dut (
        .clk(clk), .RESET(reset), .ENABLE(enable), .CIN(cin), .MODO(modo), .D(d),
        .Q(q), .RCO(rco), .LOAD(load), .COUT(cout), .WRAP_CNT(wrap_cnt)
    );

    // Loads must reach the upper slice regardless of the lower carry.
    assign hi_cin = (c_modo == 2'b11) ? 1'b1 : lo_cout;

    counter_gen2 #(.WIDTH(4), .STEP(3), .WCW(8)) u_lo (
        .clk(clk), .RESET(c_reset), .ENABLE(c_en), .CIN(1'b1), .MODO(c_modo), .D(lo_d),
        .Q(lo_q), .RCO(lo_rco), .LOAD(lo_load), .COUT(lo_cout), .WRAP_CNT(lo_wrap)
    );

    counter_gen2 #(.WIDTH(4), .STEP(3), .WCW(8)) u_hi (
        .clk(clk), .RESET(c_reset), .ENABLE(c_en), .CIN(hi_cin), .MODO(c_modo), .D(hi_d),
        .Q(hi_q), .RCO(hi_rco), .LOAD(hi_load), .COUT(hi_cout), .WRAP_CNT(hi_wrap)
    );

    function automatic bit exp_cout(int qv, logic [1:0] m, bit a);
        bit t;
        case (m)
            2'b00:   t = (qv == 15);
            2'b01:   t = (qv == 0);
            2'b10:   t = (qv < 3);
            default: t = 1'b0;
        endcase
        return a && t;
    endfunction

    // Advance the model from the currently driven inputs, then clock the DUT.
    task automatic step_cycle();
        int nq, nw;
        bit nr, nl;
        nq = m_q; nw = m_wrap; nr = 1'b0; nl = 1'b0;
        if (reset) begin
            nq = 0; nw = 0;
        end else if (enable && cin) begin
            case (modo)
                2'b00: if (m_q == 15) begin nr = 1'b1; nq = SAT ? 15 : 0; end else nq = m_q + 1;
                2'b01: if (m_q == 0) begin nr = 1'b1; nq = SAT ? 0 : 15; end else nq = m_q - 1;
                2'b10: if (m_q < 3) begin nr = 1'b1; nq = SAT ? 0 : m_q + 16 - 3; end else nq = m_q - 3;
                default: begin nq = int'(d); nl = 1'b1; nw = 0; end
            endcase
            if (nr && nw < 255) nw = nw + 1;
        end
        @(posedge clk);
        #1;
        m_q = nq; m_wrap = nw; m_rco = nr; m_load = nl;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cin = 1'b1; modo = 2'b11; d = 4'h9;
        for (int i = 0; i < 2; i++) begin
            step_cycle();
            checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
            checks++; if (rco !== 1'b0) begin errors++; $display("FAIL reset_rco got=%b exp=0", rco); end
            checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", load); end
            checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL reset_wrap got=%h exp=00", wrap_cnt); end
        end
        reset = 1'b0;
    endtask

    task automatic test_load_up();
        modo = 2'b11; d = 4'hE;
        step_cycle();
        checks++; if (q !== 4'hE) begin errors++; $display("FAIL load_q got=%h exp=E", q); end
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL load_pulse got=%b exp=1", load); end
        modo = 2'b00;
        step_cycle();
        checks++; if (q !== 4'hF) begin errors++; $display("FAIL up_q got=%h exp=F", q); end
        checks++; if (load !== 1'b0 || rco !== 1'b0) begin errors++; $display("FAIL up_flags got=%b%b exp=00", load, rco); end
        step_cycle();
        checks++; if (q !== (SAT ? 4'hF : 4'h0)) begin errors++; $display("FAIL up_wrap_q got=%h exp=%h", q, SAT ? 4'hF : 4'h0); end
        checks++; if (rco !== 1'b1) begin errors++; $display("FAIL up_wrap_rco got=%b exp=1", rco); end
        checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL up_wrap_cnt got=%0d exp=1", wrap_cnt); end
    endtask

    task automatic test_step_borrow();
        modo = 2'b11; d = 4'h2;
        step_cycle();
        modo = 2'b10;
        step_cycle();
        checks++; if (q !== (SAT ? 4'h0 : 4'hF)) begin errors++; $display("FAIL step_q got=%h exp=%h", q, SAT ? 4'h0 : 4'hF); end
        checks++; if (rco !== 1'b1) begin errors++; $display("FAIL step_rco got=%b exp=1", rco); end
`ifdef COUNTER_GEN2_SAT_EN
        step_cycle();
        checks++; if (q !== 4'h0 || rco !== 1'b1) begin errors++; $display("FAIL step_sat got q=%h rco=%b exp q=0 rco=1", q, rco); end
        checks++; if (wrap_cnt !== 8'd2) begin errors++; $display("FAIL step_sat_wrap got=%0d exp=2", wrap_cnt); end
`else
        step_cycle();
        checks++; if (q !== 4'hC || rco !== 1'b0) begin errors++; $display("FAIL step_next got q=%h rco=%b exp q=C rco=0", q, rco); end
`endif
    endtask

    task automatic test_cin_hold();
        modo = 2'b11; d = 4'hF;
        step_cycle();
        modo = 2'b00; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (cout !== 1'b0) begin errors++; $display("FAIL hold_cout got=%b exp=0", cout); end
            step_cycle();
            checks++; if (q !== 4'hF || rco !== 1'b0) begin errors++; $display("FAIL hold_q got q=%h rco=%b exp q=F rco=0", q, rco); end
        end
        cin = 1'b1;
        #1;
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL cin_cout got=%b exp=1", cout); end
        step_cycle();
        checks++; if (q !== (SAT ? 4'hF : 4'h0) || rco !== 1'b1) begin errors++; $display("FAIL cin_adv got q=%h rco=%b", q, rco); end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; enable = 1'b1; cin = 1'b1; modo = 2'b11; d = 4'h7;
        step_cycle();
        checks++; if (q !== 4'h0 || load !== 1'b0 || wrap_cnt !== 8'h00) begin
            errors++; $display("FAIL reset_prio got q=%h load=%b wrap=%h exp 0/0/00", q, load, wrap_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [3];
        vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'hA;
        modo = 2'b11;
        for (int i = 0; i < 3; i++) begin
            d = vals[i];
            step_cycle();
            checks++; if (q !== vals[i] || load !== 1'b1) begin
                errors++; $display("FAIL b2b_load got q=%h load=%b exp q=%h load=1", q, load, vals[i]);
            end
        end
    endtask

    task automatic test_wrap_saturate();
        modo = 2'b11; d = 4'h0;
        step_cycle();
        modo = 2'b01;
        for (int i = 0; i < 4200; i++) step_cycle();
        checks++; if (wrap_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_sat got=%h exp=FF", wrap_cnt); end
        checks++; if (q !== m_q[3:0]) begin errors++; $display("FAIL wrap_sat_q got=%h exp=%h", q, m_q[3:0]); end
        modo = 2'b11; d = 4'h4;
        step_cycle();
        checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL wrap_clear got=%h exp=00", wrap_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 100; i++) begin
            reset  = ($urandom_range(0, 24) == 0);
            enable = ($urandom_range(0, 7) != 0);
            cin    = ($urandom_range(0, 7) != 0);
            modo   = 2'($urandom_range(0, 3));
            d      = 4'($urandom_range(0, 15));
            #1;
            checks++; if (cout !== exp_cout(m_q, modo, enable && cin)) begin
                errors++; $display("FAIL rand_cout it=%0d got=%b exp=%b", i, cout, exp_cout(m_q, modo, enable && cin));
            end
            step_cycle();
            $display("txn %0d rst=%b en=%b cin=%b modo=%b d=%h -> q=%h rco=%b load=%b wrap=%0d",
                     i, reset, enable, cin, modo, d, q, rco, load, wrap_cnt);
            checks++; if (q !== m_q[3:0]) begin errors++; $display("FAIL rand_q it=%0d got=%h exp=%h", i, q, m_q[3:0]); end
            checks++; if (rco !== m_rco) begin errors++; $display("FAIL rand_rco it=%0d got=%b exp=%b", i, rco, m_rco); end
            checks++; if (load !== m_load) begin errors++; $display("FAIL rand_load it=%0d got=%b exp=%b", i, load, m_load); end
            checks++; if (wrap_cnt !== m_wrap[7:0]) begin errors++; $display("FAIL rand_wrap it=%0d got=%0d exp=%0d", i, wrap_cnt, m_wrap); end
        end
        reset = 1'b0;
    endtask

    task automatic test_cascade();
        logic [7:0] exp_v;
        c_reset = 1'b1; c_en = 1'b1; c_modo = 2'b00;
        @(posedge clk); #1;
        c_reset = 1'b0; c_modo = 2'b11; hi_d = 4'h0; lo_d = 4'hF;
        @(posedge clk); #1;
        checks++; if ({hi_q, lo_q} !== 8'h0F) begin errors++; $display("FAIL casc_load got=%h exp=0F", {hi_q, lo_q}); end
        c_modo = 2'b00;
        @(posedge clk); #1;
        exp_v = SAT ? 8'h1F : 8'h10;
        checks++; if ({hi_q, lo_q} !== exp_v) begin errors++; $display("FAIL casc_carry got=%h exp=%h", {hi_q, lo_q}, exp_v); end
        c_modo = 2'b11; hi_d = 4'hF; lo_d = 4'hF;
        @(posedge clk); #1;
        c_modo = 2'b00;
        #1;
        checks++; if (hi_cout !== 1'b1) begin errors++; $display("FAIL casc_hi_cout got=%b exp=1", hi_cout); end
        @(posedge clk); #1;
        exp_v = SAT ? 8'hFF : 8'h00;
        checks++; if ({hi_q, lo_q} !== exp_v) begin errors++; $display("FAIL casc_wrap got=%h exp=%h", {hi_q, lo_q}, exp_v); end
        checks++; if (hi_rco !== 1'b1) begin errors++; $display("FAIL casc_hi_rco got=%b exp=1", hi_rco); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cin = 1'b1; modo = 2'b00; d = 4'h0;
        c_reset = 1'b1; c_en = 1'b0; c_modo = 2'b00; lo_d = 4'h0; hi_d = 4'h0;
        m_q = 0; m_wrap = 0; m_rco = 1'b0; m_load = 1'b0;
        #1;
        test_reset();
        test_load_up();
        test_step_borrow();
        test_cin_hold();
        test_reset_priority();
        test_back_to_back();
        test_wrap_saturate();
        test_random();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
